ysyx_22050078_operand_stage: RTL and testbench
==============================================

Name: ysyx_22050078_operand_stage

Overview:
Register-read / operand-forwarding stage between the decoder and the execute unit.
- Accepts one decoded instruction per cycle over a valid/ready handshake.
- Drives the register-file read addresses and takes the combinational read data.
- Overrides stale register data with in-flight results from EX, MEM and WB.
- Stalls on load-use hazards.
- Registers the resolved operands toward EX and counts stall cycles.

Parameters:
CPU_WIDTH, 64, datapath width.
REG_ADDRW, 5, register address width.
CNT_WIDTH, 32, stall counter width.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous active-high
i_valid  in  1  decoded instruction valid
o_ready  out  1  stage can accept this cycle
i_rs1_addr  in  REG_ADDRW  source 1 address
i_rs2_addr  in  REG_ADDRW  source 2 address
i_rs1_used  in  1  instruction reads rs1
i_rs2_used  in  1  instruction reads rs2
i_rd_addr  in  REG_ADDRW  destination address
i_rd_wen  in  1  instruction writes rd
i_is_load  in  1  instruction is a load
o_rf_rs1_addr  out  REG_ADDRW  to register file, equals i_rs1_addr
o_rf_rs2_addr  out  REG_ADDRW  to register file, equals i_rs2_addr
i_rf_rs1_data  in  CPU_WIDTH  register file read data 1, combinational
i_rf_rs2_data  in  CPU_WIDTH  register file read data 2, combinational
i_ex_valid, i_ex_rd_wen, i_ex_is_load  in  1 each  EX-stage instruction info
i_ex_rd_addr  in  REG_ADDRW  EX-stage destination
i_ex_result  in  CPU_WIDTH  EX ALU result, same cycle
i_mem_valid, i_mem_rd_wen  in  1 each  MEM-stage instruction info
i_mem_rd_addr  in  REG_ADDRW  MEM-stage destination
i_mem_data  in  CPU_WIDTH  MEM final value, load data or passed ALU result
i_wb_wen  in  1  writeback enable, same signal as the register file write enable
i_wb_addr  in  REG_ADDRW  writeback address
i_wb_data  in  CPU_WIDTH  writeback data
i_flush  in  1  kill the held and incoming instruction
o_valid  out  1  operands valid toward EX
i_ready  in  1  EX accepts
o_src1, o_src2  out  CPU_WIDTH each  resolved operands
o_rd_addr  out  REG_ADDRW  registered destination
o_rd_wen, o_is_load  out  1 each  registered destination write enable and load flag
o_stall_cnt  out  CNT_WIDTH  load-use stall cycles

Behaviour:
- Single clock domain: clk. Reset is rst, synchronous, active-high.
- Reset values: o_valid, o_src1, o_src2, o_rd_addr, o_rd_wen, o_is_load and o_stall_cnt all 0.
- o_rf_rs*_addr are pure pass-through of i_rs*_addr (combinational).
- Operand resolution, per source n (combinational), first match wins:
  - addr == 0 gives 0. x0 is never forwarded, even if a producer reports rd=0 with wen=1.
  - i_ex_valid & i_ex_rd_wen & ~i_ex_is_load & addr match gives i_ex_result.
  - i_mem_valid & i_mem_rd_wen & addr match gives i_mem_data.
  - i_wb_wen & addr match gives i_wb_data. This is required: the register file updates only at the clock edge.
  - Otherwise i_rf_rsn_data.
- Load-use hazard (hz): i_valid & i_ex_valid & i_ex_is_load & i_ex_rd_wen & i_ex_rd_addr != 0 & ((i_rs1_used & rs1 == ex_rd) | (i_rs2_used & rs2 == ex_rd)).
- Ready: o_ready = (~o_valid | i_ready) & ~hz & ~i_flush.
- Accept (i_valid & o_ready): on the next edge, o_valid=1 and all outputs take the resolved values.
- Output drained without accept (o_valid & i_ready & ~accept): o_valid goes to 0. Data outputs hold their value; verification treats them as don't-care.
- Backpressure (o_valid & ~i_ready): all outputs hold. o_ready=0.
- One-cycle latency decode-to-EX with no stall, so full throughput is 1 instruction per cycle.
- Stall counter: o_stall_cnt increments by 1 on every cycle with hz=1 and i_flush=0. It saturates at all-ones and is cleared only by rst.
- Flush: on an i_flush edge, o_valid goes to 0 and the incoming instruction is dropped. Flush overrides accept, hazard and backpressure.
- rst has priority over i_flush and everything else. Reset asserted mid-handshake discards the held instruction.
- Simultaneous EX and MEM match on the same register: EX wins (youngest). EX is a load and MEM also matches: hazard stall; MEM is not used.

Test Plan:
- Reset with rst=1 for 2 cycles -> o_valid=0, o_src1=0, o_stall_cnt=0, o_ready=1 once rst=0 and ~o_valid.
- No hazard: rs1=5, rs2=6, register file returns 0x11 and 0x22, no producers, i_ready=1 -> next cycle o_valid=1, o_src1=0x11, o_src2=0x22; back-to-back issue each cycle.
- Forward priority: rs1=7 with EX rd=7 result 0xAA, MEM rd=7 data 0xBB, WB addr=7 data 0xCC, register file 0xDD -> o_src1=0xAA. Drop EX -> 0xBB. Drop MEM -> 0xCC. rs1=0 with EX rd=0 wen=1 -> o_src1=0.
- Load-use: EX load rd=3, incoming rs2=3 with i_rs2_used=1 -> o_ready=0 for that cycle and o_stall_cnt +1. Next cycle EX invalid, MEM rd=3 data 0x1234 -> accept, o_src2=0x1234. Same case with i_rs2_used=0 -> no stall.
- Backpressure: o_valid=1, i_ready=0 for 3 cycles with new i_valid -> outputs stable, o_ready=0. i_ready=1 -> the new instruction is captured on that same edge.
- Flush: i_flush=1 with o_valid=1 and i_valid=1 -> next cycle o_valid=0, instruction not captured. Saturation: force 2^32 stall cycles (small CNT_WIDTH=4 build: 20 cycles) -> o_stall_cnt stays at 0xF.

Source files
------------

// File: rtl/ysyx_22050078_operand_stage.sv
// ysyx_22050078_operand_stage: register read, operand forwarding and load-use stall stage
module ysyx_22050078_operand_stage #(
  parameter int CPU_WIDTH = 64,
  parameter int REG_ADDRW = 5,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [REG_ADDRW-1:0] i_rs1_addr,
  input  logic [REG_ADDRW-1:0] i_rs2_addr,
  input  logic                 i_rs1_used,
  input  logic                 i_rs2_used,
  input  logic [REG_ADDRW-1:0] i_rd_addr,
  input  logic                 i_rd_wen,
  input  logic                 i_is_load,
  output logic [REG_ADDRW-1:0] o_rf_rs1_addr,
  output logic [REG_ADDRW-1:0] o_rf_rs2_addr,
  input  logic [CPU_WIDTH-1:0] i_rf_rs1_data,
  input  logic [CPU_WIDTH-1:0] i_rf_rs2_data,
  input  logic                 i_ex_valid,
  input  logic                 i_ex_rd_wen,
  input  logic                 i_ex_is_load,
  input  logic [REG_ADDRW-1:0] i_ex_rd_addr,
  input  logic [CPU_WIDTH-1:0] i_ex_result,
  input  logic                 i_mem_valid,
  input  logic                 i_mem_rd_wen,
  input  logic [REG_ADDRW-1:0] i_mem_rd_addr,
  input  logic [CPU_WIDTH-1:0] i_mem_data,
  input  logic                 i_wb_wen,
  input  logic [REG_ADDRW-1:0] i_wb_addr,
  input  logic [CPU_WIDTH-1:0] i_wb_data,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [CPU_WIDTH-1:0] o_src1,
  output logic [CPU_WIDTH-1:0] o_src2,
  output logic [REG_ADDRW-1:0] o_rd_addr,
  output logic                 o_rd_wen,
  output logic                 o_is_load,
  output logic [CNT_WIDTH-1:0] o_stall_cnt
);
  logic                 ex_fwd, mem_fwd, hz, accept;
  logic [CPU_WIDTH-1:0] src1, src2;
  assign o_rf_rs1_addr = i_rs1_addr;
  assign o_rf_rs2_addr = i_rs2_addr;
  assign ex_fwd  = i_ex_valid & i_ex_rd_wen & ~i_ex_is_load;
  assign mem_fwd = i_mem_valid & i_mem_rd_wen;
  always_comb begin
    src1 = (i_rs1_addr == '0) ? '0 :
           (ex_fwd && i_ex_rd_addr == i_rs1_addr) ? i_ex_result :
           (mem_fwd && i_mem_rd_addr == i_rs1_addr) ? i_mem_data :
           (i_wb_wen && i_wb_addr == i_rs1_addr) ? i_wb_data : i_rf_rs1_data;
    src2 = (i_rs2_addr == '0) ? '0 :
           (ex_fwd && i_ex_rd_addr == i_rs2_addr) ? i_ex_result :
           (mem_fwd && i_mem_rd_addr == i_rs2_addr) ? i_mem_data :
           (i_wb_wen && i_wb_addr == i_rs2_addr) ? i_wb_data : i_rf_rs2_data;
  end
  assign hz = i_valid & i_ex_valid & i_ex_is_load & i_ex_rd_wen & (i_ex_rd_addr != '0) &
              ((i_rs1_used & (i_rs1_addr == i_ex_rd_addr)) | (i_rs2_used & (i_rs2_addr == i_ex_rd_addr)));
  assign o_ready = (~o_valid | i_ready) & ~hz & ~i_flush;
  assign accept  = i_valid & o_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid     <= 1'b0;
      o_src1      <= '0;
      o_src2      <= '0;
      o_rd_addr   <= '0;
      o_rd_wen    <= 1'b0;
      o_is_load   <= 1'b0;
      o_stall_cnt <= '0;
    end else begin
      if (hz && !i_flush && !(&o_stall_cnt)) o_stall_cnt <= o_stall_cnt + 1'b1;
      if (i_flush) o_valid <= 1'b0;
      else if (accept) begin
        o_valid   <= 1'b1;
        o_src1    <= src1;
        o_src2    <= src2;
        o_rd_addr <= i_rd_addr;
        o_rd_wen  <= i_rd_wen;
        o_is_load <= i_is_load;
      end else if (i_ready) o_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ysyx_22050078_operand_stage.sv
// tb_ysyx_22050078_operand_stage: randomized and directed check of the operand stage against a reference model
module tb_ysyx_22050078_operand_stage;
  localparam int W = 64;
  localparam int A = 5;
  localparam int C = 4;
  logic clk = 1'b0, rst;
  logic i_valid, o_ready, i_rs1_used, i_rs2_used, i_rd_wen, i_is_load;
  logic [A-1:0] i_rs1_addr, i_rs2_addr, i_rd_addr, o_rf_rs1_addr, o_rf_rs2_addr;
  logic [W-1:0] i_rf_rs1_data, i_rf_rs2_data, i_ex_result, i_mem_data, i_wb_data;
  logic i_ex_valid, i_ex_rd_wen, i_ex_is_load, i_mem_valid, i_mem_rd_wen, i_wb_wen;
  logic [A-1:0] i_ex_rd_addr, i_mem_rd_addr, i_wb_addr, o_rd_addr;
  logic i_flush, o_valid, i_ready, o_rd_wen, o_is_load;
  logic [W-1:0] o_src1, o_src2;
  logic [C-1:0] o_stall_cnt;
  int n_cmp = 0, n_err = 0;
  logic mv, known, mwen, mload, obs_ready;
  logic [W-1:0] ms1, ms2;
  logic [A-1:0] mrd;
  int mcnt;
  always #5 clk = ~clk;
  ysyx_22050078_operand_stage #(.CPU_WIDTH(W), .REG_ADDRW(A), .CNT_WIDTH(C)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used),
    .i_rd_addr(i_rd_addr), .i_rd_wen(i_rd_wen), .i_is_load(i_is_load),
    .o_rf_rs1_addr(o_rf_rs1_addr), .o_rf_rs2_addr(o_rf_rs2_addr),
    .i_rf_rs1_data(i_rf_rs1_data), .i_rf_rs2_data(i_rf_rs2_data),
    .i_ex_valid(i_ex_valid), .i_ex_rd_wen(i_ex_rd_wen), .i_ex_is_load(i_ex_is_load),
    .i_ex_rd_addr(i_ex_rd_addr), .i_ex_result(i_ex_result),
    .i_mem_valid(i_mem_valid), .i_mem_rd_wen(i_mem_rd_wen), .i_mem_rd_addr(i_mem_rd_addr), .i_mem_data(i_mem_data),
    .i_wb_wen(i_wb_wen), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_src1(o_src1), .o_src2(o_src2), .o_rd_addr(o_rd_addr), .o_rd_wen(o_rd_wen), .o_is_load(o_is_load),
    .o_stall_cnt(o_stall_cnt)
  );
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] resolve(input logic [A-1:0] a, input logic [W-1:0] rf);
    logic          pe[3];
    logic [A-1:0]  pa[3];
    logic [W-1:0]  pd[3];
    pe = '{i_ex_valid && i_ex_rd_wen && !i_ex_is_load, i_mem_valid && i_mem_rd_wen, i_wb_wen};
    pa = '{i_ex_rd_addr, i_mem_rd_addr, i_wb_addr};
    pd = '{i_ex_result, i_mem_data, i_wb_data};
    if (a == 0) return '0;
    for (int i = 0; i < 3; i++) if (pe[i] && pa[i] == a) return pd[i];
    return rf;
  endfunction
  task automatic idle();
    rst = 0; i_valid = 0; i_rs1_addr = 0; i_rs2_addr = 0; i_rs1_used = 0; i_rs2_used = 0;
    i_rd_addr = 0; i_rd_wen = 0; i_is_load = 0; i_rf_rs1_data = 0; i_rf_rs2_data = 0;
    i_ex_valid = 0; i_ex_rd_wen = 0; i_ex_is_load = 0; i_ex_rd_addr = 0; i_ex_result = 0;
    i_mem_valid = 0; i_mem_rd_wen = 0; i_mem_rd_addr = 0; i_mem_data = 0;
    i_wb_wen = 0; i_wb_addr = 0; i_wb_data = 0; i_flush = 0; i_ready = 1;
  endtask
  task automatic cycle();
    logic hz, rdy;
    logic [W-1:0] s1, s2;
    #1;
    hz = i_valid && i_ex_valid && i_ex_is_load && i_ex_rd_wen && i_ex_rd_addr != 0 &&
         ((i_rs1_used && i_rs1_addr == i_ex_rd_addr) || (i_rs2_used && i_rs2_addr == i_ex_rd_addr));
    rdy = (!mv || i_ready) && !hz && !i_flush;
    s1 = resolve(i_rs1_addr, i_rf_rs1_data);
    s2 = resolve(i_rs2_addr, i_rf_rs2_data);
    obs_ready = o_ready;
    if (!rst) begin
      chk("o_ready", {63'd0, o_ready}, {63'd0, rdy});
      chk("rf_addr", {54'd0, o_rf_rs1_addr, o_rf_rs2_addr}, {54'd0, i_rs1_addr, i_rs2_addr});
    end
    @(posedge clk);
    if (rst) begin
      mv = 0; known = 1; ms1 = 0; ms2 = 0; mrd = 0; mwen = 0; mload = 0; mcnt = 0;
    end else begin
      if (hz && !i_flush && mcnt < (1 << C) - 1) mcnt++;
      if (i_flush) begin
        mv = 0; known = 0;
      end else if (i_valid && rdy) begin
        mv = 1; known = 1; ms1 = s1; ms2 = s2; mrd = i_rd_addr; mwen = i_rd_wen; mload = i_is_load;
      end else if (i_ready) begin
        mv = 0; known = 0;
      end
    end
    #1;
    chk("o_valid", {63'd0, o_valid}, {63'd0, mv});
    chk("stall_cnt", {60'd0, o_stall_cnt}, mcnt[W-1:0]);
    if (known) begin
      chk("o_src1", o_src1, ms1);
      chk("o_src2", o_src2, ms2);
      chk("o_dest", {57'd0, o_rd_addr, o_rd_wen, o_is_load}, {57'd0, mrd, mwen, mload});
    end
    @(negedge clk);
  endtask
  initial begin
    mv = 0; known = 0; ms1 = 0; ms2 = 0; mrd = 0; mwen = 0; mload = 0; mcnt = 0;
    idle();
    rst = 1;
    @(negedge clk);
    cycle();
    cycle();
    rst = 0;
    #1;
    chk("rst_valid", {63'd0, o_valid}, 0);
    chk("rst_src1", o_src1, 0);
    chk("rst_cnt", {60'd0, o_stall_cnt}, 0);
    chk("rst_ready", {63'd0, o_ready}, 1);
    @(negedge clk);
    i_valid = 1; i_rs1_addr = 5; i_rs2_addr = 6; i_rs1_used = 1; i_rs2_used = 1;
    i_rd_addr = 9; i_rd_wen = 1; i_rf_rs1_data = 64'h11; i_rf_rs2_data = 64'h22;
    cycle();
    chk("nh_src1", o_src1, 64'h11);
    chk("nh_src2", o_src2, 64'h22);
    i_rf_rs1_data = 64'h33; i_rf_rs2_data = 64'h44;
    cycle();
    chk("b2b_valid", {63'd0, o_valid}, 1);
    chk("b2b_src1", o_src1, 64'h33);
    i_rs1_addr = 7; i_rf_rs1_data = 64'hDD;
    i_ex_valid = 1; i_ex_rd_wen = 1; i_ex_rd_addr = 7; i_ex_result = 64'hAA;
    i_mem_valid = 1; i_mem_rd_wen = 1; i_mem_rd_addr = 7; i_mem_data = 64'hBB;
    i_wb_wen = 1; i_wb_addr = 7; i_wb_data = 64'hCC;
    cycle();
    chk("fwd_ex", o_src1, 64'hAA);
    i_ex_valid = 0;
    cycle();
    chk("fwd_mem", o_src1, 64'hBB);
    i_mem_valid = 0;
    cycle();
    chk("fwd_wb", o_src1, 64'hCC);
    i_rs1_addr = 0; i_ex_valid = 1; i_ex_rd_addr = 0;
    cycle();
    chk("fwd_x0", o_src1, 0);
    idle();
    i_valid = 1; i_rs2_addr = 3; i_rs2_used = 1; i_rf_rs2_data = 64'h99;
    i_ex_valid = 1; i_ex_rd_wen = 1; i_ex_is_load = 1; i_ex_rd_addr = 3;
    begin
      int c0;
      c0 = mcnt;
      cycle();
      chk("lu_ready", {63'd0, obs_ready}, 0);
      chk("lu_cnt", {60'd0, o_stall_cnt}, c0 + 1);
    end
    i_ex_valid = 0; i_mem_valid = 1; i_mem_rd_wen = 1; i_mem_rd_addr = 3; i_mem_data = 64'h1234;
    cycle();
    chk("lu_mem", o_src2, 64'h1234);
    i_mem_valid = 0; i_ex_valid = 1; i_rs2_used = 0;
    cycle();
    chk("lu_unused", {63'd0, obs_ready}, 1);
    idle();
    i_valid = 1; i_rs1_addr = 1; i_rf_rs1_data = 64'h5A;
    cycle();
    i_ready = 0; i_rf_rs1_data = 64'hA5;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_ready", {63'd0, obs_ready}, 0);
      chk("bp_hold", o_src1, 64'h5A);
    end
    i_ready = 1;
    cycle();
    chk("bp_capture", o_src1, 64'hA5);
    i_flush = 1; i_rf_rs1_data = 64'h77;
    cycle();
    chk("flush_valid", {63'd0, o_valid}, 0);
    idle();
    i_valid = 1; i_rs1_addr = 2; i_rs1_used = 1;
    i_ex_valid = 1; i_ex_rd_wen = 1; i_ex_is_load = 1; i_ex_rd_addr = 2;
    for (int k = 0; k < 20; k++) cycle();
    chk("sat_cnt", {60'd0, o_stall_cnt}, 64'hF);
    for (int k = 0; k < 3000; k++) begin
      rst = $urandom_range(0, 59) == 0;
      i_valid = $urandom_range(0, 3) != 0;
      i_rs1_addr = A'($urandom_range(0, 3)); i_rs2_addr = A'($urandom_range(0, 3));
      i_rs1_used = $urandom_range(0, 1); i_rs2_used = $urandom_range(0, 1);
      i_rd_addr = A'($urandom); i_rd_wen = $urandom_range(0, 1); i_is_load = $urandom_range(0, 1);
      i_rf_rs1_data = {$urandom, $urandom}; i_rf_rs2_data = {$urandom, $urandom};
      i_ex_valid = $urandom_range(0, 1); i_ex_rd_wen = $urandom_range(0, 1);
      i_ex_is_load = $urandom_range(0, 3) == 0; i_ex_rd_addr = A'($urandom_range(0, 3));
      i_ex_result = {$urandom, $urandom};
      i_mem_valid = $urandom_range(0, 1); i_mem_rd_wen = $urandom_range(0, 1);
      i_mem_rd_addr = A'($urandom_range(0, 3)); i_mem_data = {$urandom, $urandom};
      i_wb_wen = $urandom_range(0, 1); i_wb_addr = A'($urandom_range(0, 3)); i_wb_data = {$urandom, $urandom};
      i_flush = $urandom_range(0, 11) == 0;
      i_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
